mem_stall_ctrl: RTL and testbench
=================================

MEM_STALL_CTRL -- requirements
Module: mem_stall_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 64, legal range 1..255: number of WAIT cycles without mem_done before a timeout error is raised.
REQ-002 clk  in  1  single clock; all state changes on the rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 mem_en  in  1  EX/MEM stage requests a data-memory access this cycle.
REQ-005 mem_write  in  1  access is a store (1) or a load (0); ignored when mem_en=0.
REQ-006 addr  in  16  data-memory address from EX/MEM.
REQ-007 halt  in  1  halt instruction currently in EX/MEM.
REQ-008 mem_done  in  1  memory completes the outstanding or just-issued access this cycle.
REQ-009 mem_err  in  1  memory reports an access error this cycle.
REQ-010 mem_start  out  1  one-cycle request strobe to data memory.
REQ-011 mem_wr  out  1  store qualifier for the request; valid only with mem_start.
REQ-012 stall_pipe  out  1  hold PC, IF/ID, ID/EX and EX/MEM registers.
REQ-013 wb_bubble  out  1  load a NOP into MEM/WB: Reg_write, Mem_en, halt and JAL are forced to 0.
REQ-014 mem_misalign  out  1  current mem_en access has addr[0]=1.
REQ-015 err  out  1  sticky error flag.
REQ-016 busy  out  1  state is WAIT.

Function
REQ-017 FSM states: IDLE, WAIT, HALTED and ERROR, encoded in 2 bits; a 8-bit wait counter wcnt.
REQ-018 mem_misalign = mem_en & addr[0], combinational, in every state.
REQ-019 mem_start = (state==IDLE) & mem_en & ~addr[0]; mem_wr = mem_start & mem_write.
REQ-020 IDLE, mem_en=0: stay IDLE; stall_pipe=0; wb_bubble=0.
REQ-021 IDLE, aligned access with mem_done=1 in the same cycle: single-cycle hit; stall_pipe=0; stay IDLE.
REQ-022 IDLE, aligned access with mem_done=0: stall_pipe=1 and wb_bubble=1; next state WAIT; wcnt set to 1.
REQ-023 WAIT: mem_start=0; stall_pipe = wb_bubble = ~mem_done; wcnt increments by 1 per cycle and saturates at 255.
REQ-024 WAIT with mem_done=1: next state IDLE; the stage advances that same cycle with the load data valid.
REQ-025 WAIT with mem_done=0 and wcnt==TIMEOUT: next state ERROR.
REQ-026 mem_err=1 while in IDLE with a started access, or while in WAIT: next state ERROR; this takes priority over mem_done.
REQ-027 Misaligned access in IDLE or HALTED: no mem_start; next state ERROR.
REQ-028 IDLE with halt=1 and no stall or error condition that cycle: next state HALTED.
REQ-029 halt=1 together with an aligned access in IDLE: the access completes first (through WAIT if needed), and the FSM then enters HALTED from IDLE when halt is still asserted.
REQ-030 HALTED: mem_start=0; stall_pipe=1; wb_bubble=0; remains HALTED until rst.
REQ-031 ERROR: err=1 (registered, sticky); stall_pipe=1; wb_bubble=1; mem_start=0; remains ERROR until rst.
REQ-032 err is asserted on the first cycle the state is ERROR.
REQ-033 Inputs mem_done and mem_err are ignored in IDLE when no access is started.
REQ-034 Inputs mem_done and mem_err are ignored in HALTED and in ERROR.

Reset
REQ-035 rst=1 at a clock edge forces state=IDLE, wcnt=0 and err=0, overriding every other transition, including mid-WAIT.
REQ-036 During and immediately after reset, combinational outputs follow the IDLE rules.
REQ-037 A memory access outstanding when reset is applied is abandoned; a mem_done arriving after reset is ignored.

Verification
REQ-038 Hit: mem_en=1, addr=0x0010, mem_done=1 in the same cycle -> mem_start=1 for one cycle, stall_pipe=0, state stays IDLE.
REQ-039 4-cycle load: mem_en=1, addr=0x0020, mem_done on the 4th cycle -> stall_pipe=1 and wb_bubble=1 for 3 cycles, busy=1 for 3 cycles, mem_start exactly once, state IDLE after done.
REQ-040 Misalign: mem_en=1, mem_write=1, addr=0x0021 -> mem_misalign=1 and mem_start=0 that cycle; err=1 next cycle; stall_pipe stays 1.
REQ-041 Timeout: TIMEOUT=4, mem_done held 0 -> ERROR entered after 4 WAIT cycles, err=1, later mem_done ignored.
REQ-042 Reset mid-WAIT: rst in WAIT cycle 2, then mem_done=1 -> state IDLE, err=0, stall_pipe=0, no extra mem_start.
REQ-043 Halt with access: halt=1 with aligned load, mem_done after 2 cycles -> load completes, then HALTED, stall_pipe=1, wb_bubble=0, no further mem_start.

Source files
------------

// File: rtl/mem_stall_ctrl.sv
// Data-memory stall controller: issues one access at a time, stalls the pipe while
// it is outstanding, and parks in HALTED or a sticky ERROR state until reset.
module mem_stall_ctrl #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_en,
  input  logic        mem_write,
  input  logic [15:0] addr,
  input  logic        halt,
  input  logic        mem_done,
  input  logic        mem_err,
  output logic        mem_start,
  output logic        mem_wr,
  output logic        stall_pipe,
  output logic        wb_bubble,
  output logic        mem_misalign,
  output logic        err,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_HALTED = 2'd2,
    S_ERROR  = 2'd3
  } state_t;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_t     state_q, state_d, cur_state;
  logic [7:0] wcnt_q, wcnt_d;
  logic       err_q, err_d;
  logic       busy_q, busy_d;
  logic       aligned_req;
  logic       unused_addr;

  // Only the alignment bit matters here; the rest of the address goes to memory directly.
  assign unused_addr = ^addr[15:1];

  always_comb begin
    // A stale state may still be registered while rst is high; behave as IDLE meanwhile.
    cur_state    = rst ? S_IDLE : state_q;
    aligned_req  = mem_en & ~addr[0];
    mem_misalign = mem_en & addr[0];
    mem_start    = 1'b0;
    stall_pipe   = 1'b0;
    wb_bubble    = 1'b0;
    state_d      = cur_state;
    wcnt_d       = wcnt_q;

    case (cur_state)
      S_IDLE: begin
        wcnt_d    = 8'd0;
        mem_start = aligned_req;
        if (mem_misalign) begin
          state_d    = S_ERROR;
          stall_pipe = 1'b1;
          wb_bubble  = 1'b1;
        end else if (aligned_req) begin
          if (mem_err) begin
            state_d    = S_ERROR;
            stall_pipe = 1'b1;
            wb_bubble  = 1'b1;
          end else if (mem_done) begin
            // Single-cycle hit: the stage advances, so a pending halt may take effect now.
            state_d = halt ? S_HALTED : S_IDLE;
          end else begin
            state_d    = S_WAIT;
            wcnt_d     = 8'd1;
            stall_pipe = 1'b1;
            wb_bubble  = 1'b1;
          end
        end else if (halt) begin
          state_d = S_HALTED;
        end
      end

      S_WAIT: begin
        stall_pipe = ~mem_done;
        wb_bubble  = ~mem_done;
        if (mem_err) begin
          state_d = S_ERROR;
          wcnt_d  = 8'd0;
        end else if (mem_done) begin
          state_d = S_IDLE;
          wcnt_d  = 8'd0;
        end else if (wcnt_q == TIMEOUT_C) begin
          state_d = S_ERROR;
          wcnt_d  = 8'd0;
        end else begin
          wcnt_d = (wcnt_q == 8'hFF) ? wcnt_q : wcnt_q + 8'd1;
        end
      end

      S_HALTED: begin
        stall_pipe = 1'b1;
        if (mem_misalign) begin
          state_d = S_ERROR;
        end
      end

      S_ERROR: begin
        stall_pipe = 1'b1;
        wb_bubble  = 1'b1;
      end

      default: begin
        stall_pipe = 1'b1;
        wb_bubble  = 1'b1;
        state_d    = S_ERROR;
      end
    endcase

    mem_wr = mem_start & mem_write;
    err_d  = err_q | (state_d == S_ERROR);
    busy_d = (state_d == S_WAIT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      wcnt_q  <= 8'd0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
    end
  end

  assign err  = err_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_mem_stall_ctrl.sv
// Self-checking bench for mem_stall_ctrl: flag-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_mem_stall_ctrl;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_en = 1'b0;
  logic        mem_write = 1'b0;
  logic [15:0] addr = 16'h0000;
  logic        halt = 1'b0;
  logic        mem_done = 1'b0;
  logic        mem_err = 1'b0;
  logic        mem_start, mem_wr, stall_pipe, wb_bubble, mem_misalign, err, busy;

  int n_assert = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Reference model: plain flags for "access outstanding", "halted", "errored".
  bit m_wait  = 1'b0;
  bit m_halt  = 1'b0;
  bit m_errd  = 1'b0;
  int m_cycles = 0;

  int cnt_start = 0;
  int cnt_stall = 0;
  int cnt_busy  = 0;

  mem_stall_ctrl #(.TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_en       (mem_en),
    .mem_write    (mem_write),
    .addr         (addr),
    .halt         (halt),
    .mem_done     (mem_done),
    .mem_err      (mem_err),
    .mem_start    (mem_start),
    .mem_wr       (mem_wr),
    .stall_pipe   (stall_pipe),
    .wb_bubble    (wb_bubble),
    .mem_misalign (mem_misalign),
    .err          (err),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model state advance on each rising edge.
  always @(posedge clk) begin
    if (rst) begin
      m_wait   <= 1'b0;
      m_halt   <= 1'b0;
      m_errd   <= 1'b0;
      m_cycles <= 0;
    end else if (m_errd) begin
      m_errd <= 1'b1;
    end else if (m_halt) begin
      if (mem_en && addr[0]) m_errd <= 1'b1;
    end else if (m_wait) begin
      if (mem_err) begin
        m_errd <= 1'b1;
        m_wait <= 1'b0;
      end else if (mem_done) begin
        m_wait <= 1'b0;
      end else if (m_cycles >= TO) begin
        m_errd <= 1'b1;
        m_wait <= 1'b0;
      end else begin
        m_cycles <= m_cycles + 1;
      end
    end else begin
      if (mem_en) begin
        if (addr[0] || mem_err) m_errd <= 1'b1;
        else if (!mem_done) begin
          m_wait   <= 1'b1;
          m_cycles <= 1;
        end else if (halt) m_halt <= 1'b1;
      end else if (halt) begin
        m_halt <= 1'b1;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin : monitor
    logic e_start, e_stall, e_bub, e_wr, e_mis;
    bit   idle;
    if (chk_en) begin
      idle  = rst || !(m_wait || m_halt || m_errd);
      e_mis = mem_en & addr[0];
      if (idle) begin
        e_start = mem_en & ~addr[0];
        e_stall = mem_en & (addr[0] | mem_err | ~mem_done);
        e_bub   = e_stall;
      end else if (m_errd) begin
        e_start = 1'b0; e_stall = 1'b1; e_bub = 1'b1;
      end else if (m_halt) begin
        e_start = 1'b0; e_stall = 1'b1; e_bub = 1'b0;
      end else begin
        e_start = 1'b0; e_stall = ~mem_done; e_bub = ~mem_done;
      end
      e_wr = e_start & mem_write;
      check("model_start",    32'(mem_start),    32'(e_start));
      check("model_wr",       32'(mem_wr),       32'(e_wr));
      check("model_stall",    32'(stall_pipe),   32'(e_stall));
      check("model_bubble",   32'(wb_bubble),    32'(e_bub));
      check("model_misalign", 32'(mem_misalign), 32'(e_mis));
      check("model_err",      32'(err),          32'(m_errd));
      check("model_busy",     32'(busy),         32'(m_wait));
    end
  end

  task automatic apply(input bit r, input bit en, input bit wr, input logic [15:0] a,
                       input bit h, input bit d, input bit e);
    @(posedge clk);
    #1;
    rst = r; mem_en = en; mem_write = wr; addr = a; halt = h; mem_done = d; mem_err = e;
    @(negedge clk);
    if (mem_start)  cnt_start++;
    if (stall_pipe) cnt_stall++;
    if (busy)       cnt_busy++;
  endtask

  task automatic idle_cyc();
    apply(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    apply(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    idle_cyc();
  endtask

  task automatic clr_cnt();
    cnt_start = 0; cnt_stall = 0; cnt_busy = 0;
  endtask

  initial begin
    // Reset state
    apply(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    chk_en = 1'b1;
    apply(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    check("rst_stall", 32'(stall_pipe), 32'd0);
    check("rst_err",   32'(err),        32'd0);
    check("rst_busy",  32'(busy),       32'd0);
    idle_cyc();

    // Single-cycle hit
    apply(1'b0, 1'b1, 1'b0, 16'h0010, 1'b0, 1'b1, 1'b0);
    check("hit_start", 32'(mem_start),  32'd1);
    check("hit_stall", 32'(stall_pipe), 32'd0);
    idle_cyc();
    check("hit_busy_after", 32'(busy), 32'd0);

    // Store hit qualifies mem_wr
    apply(1'b0, 1'b1, 1'b1, 16'h0012, 1'b0, 1'b1, 1'b0);
    check("store_wr", 32'(mem_wr), 32'd1);

    // 4-cycle load
    clr_cnt();
    apply(1'b0, 1'b1, 1'b0, 16'h0020, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 1'b1, 1'b0, 16'h0020, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 1'b1, 1'b0, 16'h0020, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 1'b1, 1'b0, 16'h0020, 1'b0, 1'b1, 1'b0);
    check("load4_stall_on_done", 32'(stall_pipe), 32'd0);
    idle_cyc();
    check("load4_starts", 32'(cnt_start), 32'd1);
    check("load4_stalls", 32'(cnt_stall), 32'd3);
    check("load4_busy",   32'(cnt_busy),  32'd3);
    check("load4_idle",   32'(busy),      32'd0);

    // Halt with an aligned load: load completes first, then HALTED
    clr_cnt();
    apply(1'b0, 1'b1, 1'b0, 16'h0030, 1'b1, 1'b0, 1'b0);
    apply(1'b0, 1'b1, 1'b0, 16'h0030, 1'b1, 1'b0, 1'b0);
    apply(1'b0, 1'b1, 1'b0, 16'h0030, 1'b1, 1'b1, 1'b0);
    apply(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    apply(1'b0, 1'b1, 1'b0, 16'h0040, 1'b1, 1'b1, 1'b0);
    check("halt_stall",  32'(stall_pipe), 32'd1);
    check("halt_bubble", 32'(wb_bubble),  32'd0);
    check("halt_start",  32'(mem_start),  32'd0);
    apply(1'b0, 1'b1, 1'b0, 16'h0042, 1'b1, 1'b0, 1'b1);
    check("halt_starts_total", 32'(cnt_start), 32'd1);
    check("halt_err_ignored",  32'(err),       32'd0);
    do_reset();

    // Misaligned store
    apply(1'b0, 1'b1, 1'b1, 16'h0021, 1'b0, 1'b0, 1'b0);
    check("mis_flag",  32'(mem_misalign), 32'd1);
    check("mis_start", 32'(mem_start),    32'd0);
    check("mis_stall", 32'(stall_pipe),   32'd1);
    idle_cyc();
    check("mis_err",        32'(err),        32'd1);
    check("mis_stall_next", 32'(stall_pipe), 32'd1);
    do_reset();
    check("mis_err_cleared", 32'(err), 32'd0);

    // Timeout after TO wait cycles
    apply(1'b0, 1'b1, 1'b0, 16'h0050, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < TO; i++) apply(1'b0, 1'b1, 1'b0, 16'h0050, 1'b0, 1'b0, 1'b0);
    check("to_err_last_wait",  32'(err),  32'd0);
    check("to_busy_last_wait", 32'(busy), 32'd1);
    apply(1'b0, 1'b1, 1'b0, 16'h0050, 1'b0, 1'b1, 1'b0);
    check("to_err",        32'(err),        32'd1);
    check("to_stall",      32'(stall_pipe), 32'd1);
    check("to_start_none", 32'(mem_start),  32'd0);
    idle_cyc();
    check("to_err_sticky", 32'(err), 32'd1);
    do_reset();

    // Reset in the second WAIT cycle abandons the access
    clr_cnt();
    apply(1'b0, 1'b1, 1'b0, 16'h0060, 1'b0, 1'b0, 1'b0);
    apply(1'b0, 1'b1, 1'b0, 16'h0060, 1'b0, 1'b0, 1'b0);
    apply(1'b1, 1'b0, 1'b0, 16'h0060, 1'b0, 1'b0, 1'b0);
    check("rstw_stall_during", 32'(stall_pipe), 32'd0);
    apply(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    check("rstw_stall", 32'(stall_pipe), 32'd0);
    check("rstw_err",   32'(err),        32'd0);
    check("rstw_busy",  32'(busy),       32'd0);
    idle_cyc();
    check("rstw_starts", 32'(cnt_start), 32'd1);

    // mem_err on a started access outranks mem_done
    apply(1'b0, 1'b1, 1'b0, 16'h0070, 1'b0, 1'b1, 1'b1);
    check("merr_start", 32'(mem_start), 32'd1);
    idle_cyc();
    check("merr_err", 32'(err), 32'd1);
    do_reset();

    // mem_done/mem_err ignored with no access; HALTED then misalign -> ERROR
    apply(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
    idle_cyc();
    check("ign_err", 32'(err), 32'd0);
    apply(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    apply(1'b0, 1'b1, 1'b0, 16'h0081, 1'b0, 1'b0, 1'b0);
    check("hmis_err_before", 32'(err), 32'd0);
    idle_cyc();
    check("hmis_err", 32'(err), 32'd1);
    do_reset();

    // Mixed vectors checked by the model only
    for (int i = 0; i < 400; i++) begin
      bit          r, en, wr, h, d, e;
      logic [15:0] a;
      r  = ($urandom_range(0, 19) == 0);
      en = $urandom_range(0, 1) == 1;
      wr = $urandom_range(0, 1) == 1;
      a  = 16'($urandom) & 16'hFFFE;
      if ($urandom_range(0, 24) == 0) a[0] = 1'b1;
      h  = ($urandom_range(0, 14) == 0);
      d  = ($urandom_range(0, 2) == 0);
      e  = ($urandom_range(0, 29) == 0);
      apply(r, en, wr, a, h, d, e);
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
